// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit_if
// Description : Bundles the instruction-memory req/ack bus and the fetch-to-
//               decode handshake of fetch_pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] immext;
  logic        misalign_err;
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, instr, opcode, pc, instr_valid,
           misalign_err, fetch_err,
    input  imem_ack, imem_rdata, instr_ready, branch_taken, immext
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, pc, instr_valid,
           misalign_err, fetch_err,
    output imem_ack, imem_rdata, instr_ready, branch_taken, immext
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Instruction-fetch stage: owns the PC, fetches one word per
//               req/ack handshake and presents it to decode. Optional imem
//               timeout detection is enabled with macro FETCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  wire               clk,
  input  wire               rst_n,
  fetch_pc_unit_if.master   bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FETCH = 2'd1;
  localparam logic [1:0] c_HOLD  = 2'd2;
  localparam logic [1:0] c_TRAP  = 2'd3;

  localparam logic [31:0] c_NOP  = 32'h0000_0013;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_misalign;

  logic [31:0] w_target;
  logic        w_timeout;

  // Target is only consumed in HOLD with instr_ready, so it can be computed freely.
  assign w_target = bus.branch_taken ? (r_pc + bus.immext) : (r_pc + 32'd4);

`ifdef FETCH_TIMEOUT_EN
  localparam int c_WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_WAIT_W-1:0] r_wait;
  logic                r_fetch_err;

  // The Nth consecutive ack-less FETCH cycle is the one where r_wait == N-1.
  assign w_timeout = (r_wait == c_WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait      <= '0;
      r_fetch_err <= 1'b0;
    end else if (r_state != c_FETCH) begin
      r_wait <= '0;
    end else if (!bus.imem_ack) begin
      r_wait <= r_wait + 1'b1;
      if (w_timeout) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  assign bus.fetch_err = r_fetch_err;
`else
  assign w_timeout     = 1'b0;
  assign bus.fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= c_NOP;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_state <= c_FETCH;
        end
        c_FETCH: begin
          if (bus.imem_ack) begin
            r_instr <= bus.imem_rdata;
            r_state <= c_HOLD;
          end else if (w_timeout) begin
            r_state <= c_TRAP;
          end
        end
        c_HOLD: begin
          if (bus.instr_ready) begin
            if (w_target[1:0] != 2'b00) begin
              r_misalign <= 1'b1;
              r_state    <= c_TRAP;
            end else begin
              r_pc    <= w_target;
              r_state <= c_FETCH;
            end
          end
        end
        default: begin
          r_state <= c_TRAP;
        end
      endcase
    end
  end

  assign bus.imem_req     = (r_state == c_FETCH);
  assign bus.imem_addr    = r_pc;
  assign bus.instr_valid  = (r_state == c_HOLD);
  assign bus.instr        = r_instr;
  assign bus.opcode       = r_instr[6:0];
  assign bus.pc           = r_pc;
  assign bus.misalign_err = r_misalign;

endmodule
`default_nettype wire
